mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Responder side of the control unit's memory request signals (iREN, dREN, dWEN).
- Accepts instruction-fetch and data requests from the datapath and serialises them onto the single-ported RAM.
- Returns one-cycle ihit/dhit strobes with load data.
- Sits between datapath/control unit and RAM; owns arbitration, wait-state tracking, timeout fault and halt quiescing.

Parameters:
TIMEOUT, 64, max cycles a transaction may wait for ramstate==ACCESS before FAULT (legal range 2..255)
CNT_W, 8, wait counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction fetch request, level, held until ihit
iaddr  in  32  fetch address (word_t)
dREN  in  1  data read request, level, held until dhit
dWEN  in  1  data write request, level, held until dhit
daddr  in  32  data address (word_t)
dstore  in  32  write data (word_t)
halt  in  1  datapath halt; stop accepting new requests
ihit  out  1  fetch complete, one-cycle strobe
iload  out  32  fetch data, valid only with ihit
dhit  out  1  data access complete, one-cycle strobe
dload  out  32  read data, valid only with dhit (0 on writes)
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
fault  out  1  sticky error flag
halted  out  1  arbiter quiesced after halt

Behaviour:
- Single clock CLK; reset is asynchronous, active-low on nRST.
- Reset values: all outputs 0; state IDLE; latched addr/data/write flag 0; wait counter 0.
- States: IDLE, DATA, INSTR, FAULT, HALTED.
- IDLE, arbitration priority:
  - halt=1 -> HALTED (halt takes priority over pending requests).
  - Else dREN|dWEN -> DATA. Latch daddr, dstore, wr=dWEN. dWEN wins if dREN and dWEN are both high; this is not a fault.
  - Else iREN -> INSTR. Latch iaddr.
  - Else stay in IDLE.
  - When dREN and iREN are simultaneous, data wins; the fetch is served after the data completes.
- DATA/INSTR:
  - Drive ramaddr from the latch. ramREN=1 (ramWEN=1 and ramstore=latch if wr). No other RAM outputs asserted.
  - ramstate==ACCESS: same-cycle combinational hit. dhit=1 with dload=ramload (reads; 0 on writes), or ihit=1 with iload=ramload. Next state IDLE.
  - ramstate==ERROR -> FAULT, no hit.
  - FREE/BUSY: increment the wait counter. If the counter reaches TIMEOUT-1 without ACCESS -> FAULT.
- Minimum latency: request sampled in IDLE at cycle 0, RAM driven at cycle 1, hit at cycle 1 if RAM answers ACCESS immediately.
- Mandatory one-cycle IDLE bubble after every hit. This lets the requester drop or change its request, so a still-high dREN is never re-issued as a duplicate.
- Request deasserted mid-transaction: the latched transaction still completes and the hit still pulses. Request inputs are ignored outside IDLE.
- halt asserted during DATA/INSTR: finish the transaction (hit pulses), pass through IDLE, then HALTED.
- HALTED: halted=1; RAM enables 0; no hits. Exit only by reset.
- FAULT: fault=1; RAM enables 0; no hits. Exit only by reset.
- Wait counter clears on every entry to DATA/INSTR.
- ramaddr/ramstore are 0 whenever RAM enables are 0.
- Reset asserted mid-transaction: enables drop immediately (asynchronously); no hit is issued.

Decomposition:
- Shared package mem_arb_pkg: arb_state_t enum; TIMEOUT default constant.
- word_t and ramstate_t come from cpu_types_pkg.
- Sub-module mem_wait_timer: counter with clear, enable and expired output, parameterised by TIMEOUT/CNT_W.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0004, ramstate ACCESS at first drive with ramload=0x2408_0001 -> ramREN=1 and ramaddr=0x4 at cycle 1; ihit=1 and iload=0x2408_0001 at cycle 1; ihit=0 at cycle 2.
- dREN=1, daddr=0x100 and iREN=1, iaddr=0x8 together, RAM BUSY 2 cycles then ACCESS -> dhit at cycle 3; IDLE at cycle 4; ramaddr=0x8 at cycle 5; ihit when RAM next returns ACCESS.
- dWEN=1, dREN=1, daddr=0x200, dstore=0xDEAD_BEEF -> ramWEN=1, ramstore=0xDEAD_BEEF; dhit with dload=0.
- RAM held BUSY with TIMEOUT=4 -> fault=1 after 4 cycles in DATA; enables 0; no hit; stays until nRST pulse.
- ramstate=ERROR during INSTR -> FAULT next cycle; ihit never asserted.
- halt=1 during DATA with ACCESS two cycles later -> dhit pulses, then IDLE, then halted=1; later iREN ignored.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Common CPU-wide types: machine word and the RAM handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;
endpackage

// File: rtl/mem_arb_pkg.sv
// Arbiter state encoding and default timing constants.
package mem_arb_pkg;
    localparam int TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT   = 8;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INSTR,
        FAULT,
        HALTED
    } arb_state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts RAM wait cycles for the transaction in flight; expired flags the
// last permitted wait cycle so the arbiter can fault on it.
module mem_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);
endmodule

// File: rtl/mem_request_arbiter.sv
// Serialises instruction-fetch and data requests onto a single-ported RAM,
// returning one-cycle hit strobes; handles timeout fault and halt quiescing.
module mem_request_arbiter
    import cpu_types_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      halt,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      fault,
    output logic      halted
);
    arb_state_t state;
    word_t      addr_q;
    word_t      data_q;
    logic       wr_q;
    logic       busy;
    logic       waiting;
    logic       expired;

    assign busy    = (state == DATA) || (state == INSTR);
    assign waiting = busy && ((ramstate == FREE) || (ramstate == BUSY));

    // Counter is held clear in IDLE so every new transaction starts from zero.
    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (nRST),
        .clear   (state == IDLE),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            fault  <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (dREN || dWEN) begin
                        state  <= DATA;
                        addr_q <= daddr;
                        data_q <= dstore;
                        wr_q   <= dWEN;
                    end else if (iREN) begin
                        state  <= INSTR;
                        addr_q <= iaddr;
                        data_q <= '0;
                        wr_q   <= 1'b0;
                    end
                end
                DATA, INSTR: begin
                    // Hit always returns to IDLE, giving the requester a bubble
                    // to drop its level request before it can be re-sampled.
                    if (ramstate == ACCESS) begin
                        state <= IDLE;
                    end else if ((ramstate == ERROR) || expired) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                FAULT, HALTED: state <= state;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = busy;
        ramWEN   = busy && wr_q;
        ramaddr  = busy ? addr_q : '0;
        ramstore = (busy && wr_q) ? data_q : '0;
        ihit     = (state == INSTR) && (ramstate == ACCESS);
        dhit     = (state == DATA) && (ramstate == ACCESS);
        iload    = ihit ? ramload : '0;
        dload    = (dhit && !wr_q) ? ramload : '0;
    end
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter with hand-computed expectations.
module tb_mem_request_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN, halt;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      ihit, dhit, ramREN, ramWEN, fault, halted;
    word_t     iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_bad = 0;

    mem_request_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
        .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .halt(halt),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .fault(fault), .halted(halted)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0; halt = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Advance to the middle of the next cycle; callers drive, wait #1, then check.
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        #12;
        n_cmp++; if ({ihit, dhit, ramREN, ramWEN, fault, halted} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b want 000000", {ihit, dhit, ramREN, ramWEN, fault, halted}); end
        n_cmp++; if ({iload, dload, ramaddr, ramstore} !== 128'b0) begin n_bad++; $display("FAIL reset_buses got %h want 0", {iload, dload, ramaddr, ramstore}); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_fetch();
        step(); iREN = 1; iaddr = 32'h4; ramstate = ACCESS; ramload = 32'h2408_0001; #1;
        n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL fetch_c0_ren got %b want 0", ramREN); end
        step(); #1;
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h4) begin n_bad++; $display("FAIL fetch_c1_ram got %b/%h want 1/00000004", ramREN, ramaddr); end
        n_cmp++; if (ihit !== 1'b1 || iload !== 32'h2408_0001) begin n_bad++; $display("FAIL fetch_c1_hit got %b/%h want 1/24080001", ihit, iload); end
        step(); iREN = 0; #1;
        n_cmp++; if (ihit !== 1'b0 || ramREN !== 1'b0) begin n_bad++; $display("FAIL fetch_c2_bubble got ihit=%b ren=%b want 0/0", ihit, ramREN); end
        do_reset();
    endtask

    task automatic test_priority();
        step(); dREN = 1; daddr = 32'h100; iREN = 1; iaddr = 32'h8; ramstate = BUSY; #1;
        step(); #1;
        n_cmp++; if (ramaddr !== 32'h100 || ramREN !== 1'b1) begin n_bad++; $display("FAIL prio_c1_addr got %h/%b want 00000100/1", ramaddr, ramREN); end
        step(); #1;
        n_cmp++; if (dhit !== 1'b0 || ihit !== 1'b0) begin n_bad++; $display("FAIL prio_c2_nohit got %b/%b want 0/0", dhit, ihit); end
        step(); ramstate = ACCESS; ramload = 32'h11; #1;
        n_cmp++; if (dhit !== 1'b1 || dload !== 32'h11 || ihit !== 1'b0) begin n_bad++; $display("FAIL prio_c3_dhit got %b/%h/%b want 1/00000011/0", dhit, dload, ihit); end
        step(); dREN = 0; ramstate = BUSY; #1;
        n_cmp++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dhit !== 1'b0) begin n_bad++; $display("FAIL prio_c4_idle got %b/%h/%b want 0/0/0", ramREN, ramaddr, dhit); end
        step(); #1;
        n_cmp++; if (ramaddr !== 32'h8 || ramREN !== 1'b1 || ihit !== 1'b0) begin n_bad++; $display("FAIL prio_c5_fetch got %h/%b/%b want 00000008/1/0", ramaddr, ramREN, ihit); end
        step(); ramstate = ACCESS; ramload = 32'h22; #1;
        n_cmp++; if (ihit !== 1'b1 || iload !== 32'h22) begin n_bad++; $display("FAIL prio_c6_ihit got %b/%h want 1/00000022", ihit, iload); end
        step(); iREN = 0; #1;
        n_cmp++; if (ihit !== 1'b0 || ramREN !== 1'b0) begin n_bad++; $display("FAIL prio_c7_idle got %b/%b want 0/0", ihit, ramREN); end
        do_reset();
    endtask

    task automatic test_write();
        step(); dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = ACCESS; ramload = 32'h55; #1;
        step(); #1;
        n_cmp++; if (ramWEN !== 1'b1 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h200) begin n_bad++; $display("FAIL write_ram got %b/%h/%h want 1/deadbeef/00000200", ramWEN, ramstore, ramaddr); end
        n_cmp++; if (dhit !== 1'b1 || dload !== 32'h0) begin n_bad++; $display("FAIL write_hit got %b/%h want 1/00000000", dhit, dload); end
        step(); dWEN = 0; dREN = 0; #1;
        n_cmp++; if (ramWEN !== 1'b0 || ramstore !== 32'h0 || dhit !== 1'b0) begin n_bad++; $display("FAIL write_after got %b/%h/%b want 0/0/0", ramWEN, ramstore, dhit); end
        do_reset();
    endtask

    task automatic test_timeout();
        step(); dREN = 1; daddr = 32'h300; ramstate = BUSY; #1;
        for (int c = 1; c <= 4; c++) begin
            step(); #1;
            n_cmp++; if (fault !== 1'b0 || ramREN !== 1'b1) begin n_bad++; $display("FAIL tmo_wait_c%0d got fault=%b ren=%b want 0/1", c, fault, ramREN); end
        end
        step(); dREN = 0; #1;
        n_cmp++; if (fault !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h0 || dhit !== 1'b0) begin n_bad++; $display("FAIL tmo_fault got %b/%b/%h/%b want 1/0/0/0", fault, ramREN, ramaddr, dhit); end
        step(); dREN = 1; ramstate = ACCESS; #1;
        n_cmp++; if (fault !== 1'b1 || dhit !== 1'b0 || ramREN !== 1'b0) begin n_bad++; $display("FAIL tmo_sticky got %b/%b/%b want 1/0/0", fault, dhit, ramREN); end
        #1 nRST = 1'b0; #1;
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL tmo_reset_clear got %b want 0", fault); end
        do_reset();
    endtask

    task automatic test_error();
        step(); iREN = 1; iaddr = 32'h40; ramstate = FREE; #1;
        step(); ramstate = ERROR; #1;
        n_cmp++; if (ihit !== 1'b0 || ramREN !== 1'b1 || ramaddr !== 32'h40) begin n_bad++; $display("FAIL err_c1 got %b/%b/%h want 0/1/00000040", ihit, ramREN, ramaddr); end
        step(); ramstate = ACCESS; #1;
        n_cmp++; if (fault !== 1'b1 || ihit !== 1'b0 || ramREN !== 1'b0) begin n_bad++; $display("FAIL err_fault got %b/%b/%b want 1/0/0", fault, ihit, ramREN); end
        do_reset();
    endtask

    task automatic test_halt();
        step(); dREN = 1; daddr = 32'h400; ramstate = BUSY; #1;
        step(); halt = 1; #1;
        n_cmp++; if (dhit !== 1'b0 || halted !== 1'b0 || ramREN !== 1'b1) begin n_bad++; $display("FAIL halt_c1 got %b/%b/%b want 0/0/1", dhit, halted, ramREN); end
        step(); #1;
        step(); ramstate = ACCESS; ramload = 32'h77; #1;
        n_cmp++; if (dhit !== 1'b1 || dload !== 32'h77 || halted !== 1'b0) begin n_bad++; $display("FAIL halt_finish got %b/%h/%b want 1/00000077/0", dhit, dload, halted); end
        step(); dREN = 0; iREN = 1; iaddr = 32'h500; #1;
        n_cmp++; if (ramREN !== 1'b0 || halted !== 1'b0 || ihit !== 1'b0) begin n_bad++; $display("FAIL halt_idle got %b/%b/%b want 0/0/0", ramREN, halted, ihit); end
        step(); #1;
        n_cmp++; if (halted !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0) begin n_bad++; $display("FAIL halt_entered got %b/%b/%b want 1/0/0", halted, ramREN, ihit); end
        step(); halt = 0; #1;
        n_cmp++; if (halted !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h0) begin n_bad++; $display("FAIL halt_stays got %b/%b/%h want 1/0/0", halted, ramREN, ramaddr); end
        do_reset();
    endtask

    task automatic test_halt_priority();
        step(); halt = 1; dREN = 1; daddr = 32'h600; ramstate = ACCESS; #1;
        step(); #1;
        n_cmp++; if (halted !== 1'b1 || ramREN !== 1'b0 || dhit !== 1'b0) begin n_bad++; $display("FAIL haltprio got %b/%b/%b want 1/0/0", halted, ramREN, dhit); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        step(); dREN = 1; daddr = 32'h700; ramstate = BUSY; #1;
        step(); #1;
        n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL rstmid_active got %b want 1", ramREN); end
        ramstate = ACCESS; nRST = 1'b0; #1;
        n_cmp++; if (ramREN !== 1'b0 || dhit !== 1'b0 || ramaddr !== 32'h0) begin n_bad++; $display("FAIL rstmid_drop got %b/%b/%h want 0/0/0", ramREN, dhit, ramaddr); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_timeout();
        test_error();
        test_halt();
        test_halt_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
